// File: rtl/game_pkg.sv
// Shared types and helpers for the round timer and the 7-segment scanner.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned BCD_W    = 4;
  localparam int unsigned BCD_IN_W = 7;

  // Subtract-and-compare chain; input is at most 99, so nine steps suffice.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input logic [BCD_IN_W-1:0] value);
    logic [BCD_IN_W-1:0] rem;
    logic [BCD_W-1:0]    tens;
    rem  = value;
    tens = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (rem >= BCD_IN_W'(10)) begin
        rem  = rem - BCD_IN_W'(10);
        tens = tens + BCD_W'(1);
      end
    end
    return {tens, rem[BCD_W-1:0]};
  endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control and status bundle between the round timer and the game logic.
interface game_timer_if import game_pkg::*; #(
  parameter int unsigned SEC_W = 7
) ();

  logic [SEC_W-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic [SEC_W-1:0] secs;
  logic [BCD_W-1:0] secs_tens;
  logic [BCD_W-1:0] secs_ones;
  logic             running;
  logic             expired;
  logic             tick_lost;

  modport master (
    output load_val, start, pause, abort,
    input  secs, secs_tens, secs_ones, running, expired, tick_lost
  );

  modport slave (
    input  load_val, start, pause, abort,
    output secs, secs_tens, secs_ones, running, expired, tick_lost
  );

endinterface

// File: rtl/tick_edge_sync.sv
// Samples an asynchronous slow square wave and emits a registered one-cycle
// pulse per rising edge.
module tick_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d[0] = tick_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign tick_rise = rise_q;

endmodule

// File: rtl/game_timer.sv
// Game-round countdown driven by the 1 Hz tick, with BCD digit registers and
// a watchdog that flags a missing tick stream.
module game_timer import game_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 75_000_000,
  parameter int unsigned MAX_SECS    = 99,
  parameter int unsigned SEC_W       = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_in,
  game_timer_if.slave  tmr
);

  localparam int unsigned      WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYC);
  localparam logic [SEC_W-1:0] MAX_LV = SEC_W'(MAX_SECS);

  state_t           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             lost_q, lost_d;

  logic             tick_rise;
  logic [SEC_W-1:0] lv;
  logic             start_ok;

  tick_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .clk       (clk),
    .rst       (rst),
    .tick_in   (tick_in),
    .tick_rise (tick_rise)
  );

  always_comb begin
    lv       = (tmr.load_val > MAX_LV) ? MAX_LV : tmr.load_val;
    start_ok = tmr.start && (lv != '0) && !tmr.abort;

    state_d   = state_q;
    secs_d    = secs_q;
    expired_d = 1'b0;

    // Priority abort > start > pause > tick; tick is dropped when outranked.
    if (tmr.abort) begin
      state_d = IDLE;
      secs_d  = '0;
    end else if (start_ok) begin
      secs_d  = lv;
      state_d = tmr.pause ? PAUSED : RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (tmr.pause) begin
            state_d = PAUSED;
          end else if (tick_rise) begin
            if (secs_q > SEC_W'(1)) begin
              secs_d = secs_q - SEC_W'(1);
            end else begin
              secs_d    = '0;
              expired_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
        PAUSED: begin
          if (!tmr.pause) state_d = RUN;
        end
        default: ;
      endcase
    end

    running_d        = (state_d == RUN);
    {tens_d, ones_d} = to_bcd2(BCD_IN_W'(secs_d));
  end

  always_comb begin
    wd_d = wd_q;
    if (tick_rise) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_W'(1);
    end

    lost_d = lost_q;
    if (start_ok) begin
      lost_d = 1'b0;
    end else if (wd_d == WD_MAX) begin
      lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      secs_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      wd_q      <= '0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      expired_q <= expired_d;
      wd_q      <= wd_d;
      lost_q    <= lost_d;
    end
  end

  assign tmr.secs      = secs_q;
  assign tmr.secs_tens = tens_q;
  assign tmr.secs_ones = ones_q;
  assign tmr.running   = running_q;
  assign tmr.expired   = expired_q;
  assign tmr.tick_lost = lost_q;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: a behavioural model queues the expected
// outputs each edge, a negedge monitor pops and compares them.
module tb_game_timer;

  localparam int unsigned SEC_W = 7;
  localparam int unsigned T_CYC = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_in;
  logic tick_en = 1'b1;
  int   phase = 0;

  int errs   = 0;
  int checks = 0;
  int exp_cnt = 0;

  game_timer_if #(.SEC_W(SEC_W)) bus ();

  game_timer #(
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (T_CYC),
    .MAX_SECS    (99),
    .SEC_W       (SEC_W)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .tmr     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] secs;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       lost;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} mst_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, req, $time);
    end
  endtask

  // Reference model: tick_rise after edge n is sample(n-2) & ~sample(n-3).
  mst_t       m_st   = M_IDLE;
  int         m_secs = 0;
  logic       m_exp  = 1'b0;
  logic       m_rise = 1'b0;
  logic [2:0] m_hist = 3'b000;
  int         m_wd   = 0;
  logic       m_lost = 1'b0;

  always @(posedge clk) begin
    int   lv;
    logic acc;
    logic rise_now;
    exp_t e;
    if (rst) begin
      m_st = M_IDLE; m_secs = 0; m_exp = 1'b0; m_rise = 1'b0;
      m_hist = 3'b000; m_wd = 0; m_lost = 1'b0;
    end else begin
      rise_now = m_rise;
      lv  = (int'(bus.load_val) > 99) ? 99 : int'(bus.load_val);
      acc = bus.start && (lv != 0) && !bus.abort;
      m_exp = 1'b0;
      if (bus.abort) begin
        m_st = M_IDLE; m_secs = 0;
      end else if (acc) begin
        m_secs = lv;
        m_st = bus.pause ? M_PAUSED : M_RUN;
      end else if (m_st == M_RUN) begin
        if (bus.pause) m_st = M_PAUSED;
        else if (rise_now) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            m_exp = 1'b1;
            m_st  = M_DONE;
          end
        end
      end else if (m_st == M_PAUSED && !bus.pause) begin
        m_st = M_RUN;
      end
      m_wd   = rise_now ? 0 : ((m_wd < T_CYC) ? m_wd + 1 : T_CYC);
      m_lost = acc ? 1'b0 : (m_lost || (m_wd == T_CYC));
      m_rise = m_hist[1] & ~m_hist[2];
      m_hist = {m_hist[1:0], tick_in};
    end
    e.secs    = 7'(m_secs);
    e.tens    = 4'(m_secs / 10);
    e.ones    = 4'(m_secs % 10);
    e.running = (m_st == M_RUN);
    e.expired = m_exp;
    e.lost    = m_lost;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_secs",    bus.secs,      e.secs);
      check("sb_tens",    bus.secs_tens, e.tens);
      check("sb_ones",    bus.secs_ones, e.ones);
      check("sb_running", bus.running,   e.running);
      check("sb_expired", bus.expired,   e.expired);
      check("sb_lost",    bus.tick_lost, e.lost);
      if (bus.expired) exp_cnt++;
    end
  end

  initial begin
    tick_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_in = tick_en && (phase < 5);
      phase   = (phase == 9) ? 0 : phase + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_secs(input string tag, input int val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(bus.secs) == val) break;
      cyc(1);
    end
    check(tag, bus.secs, val);
  endtask

  task automatic wait_rise(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_rise) break;
      cyc(1);
    end
    check(tag, m_rise, 1);
  endtask

  task automatic do_start(input int val);
    bus.load_val = SEC_W'(val);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    int e0;
    bus.load_val = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    cyc(3);
    check("rst_secs", bus.secs, 0);
    check("rst_running", bus.running, 0);
    check("rst_lost", bus.tick_lost, 0);
    rst = 1'b0;

    // Normal round
    cyc(4);
    e0 = exp_cnt;
    do_start(3);
    check("rnd_load", bus.secs, 3);
    check("rnd_ones", bus.secs_ones, 3);
    check("rnd_running", bus.running, 1);
    wait_secs("rnd_reach0", 0, 60);
    cyc(2);
    check("rnd_exp_cnt", exp_cnt - e0, 1);
    check("rnd_done_run", bus.running, 0);

    // Pause across two tick rises
    e0 = exp_cnt;
    do_start(5);
    wait_secs("pz_reach4", 4, 30);
    bus.pause = 1'b1;
    cyc(22);
    check("pz_hold", bus.secs, 4);
    check("pz_running", bus.running, 0);
    bus.pause = 1'b0;
    wait_secs("pz_reach0", 0, 70);
    cyc(2);
    check("pz_exp_cnt", exp_cnt - e0, 1);

    // Clamp and zero load
    do_start(120);
    check("clamp_secs", bus.secs, 99);
    check("clamp_tens", bus.secs_tens, 9);
    check("clamp_ones", bus.secs_ones, 9);
    cyc(3);
    do_start(0);
    check("zero_running", bus.running, 1);
    check("zero_tens", bus.secs_tens, 9);

    // Start colliding with a tick rise
    wait_rise("col_rise", 20);
    do_start(10);
    check("col_secs", bus.secs, 10);

    // Abort together with start
    e0 = exp_cnt;
    bus.abort = 1'b1;
    do_start(5);
    bus.abort = 1'b0;
    check("abort_secs", bus.secs, 0);
    check("abort_running", bus.running, 0);
    cyc(3);
    check("abort_no_exp", exp_cnt - e0, 0);

    // Watchdog: ticks stop right after a rise pulse
    wait_rise("wd_rise", 20);
    tick_en = 1'b0;
    cyc(20);
    check("wd_before", bus.tick_lost, 0);
    cyc(1);
    check("wd_flag", bus.tick_lost, 1);
    cyc(4);
    tick_en = 1'b1;
    cyc(30);
    check("wd_sticky", bus.tick_lost, 1);
    do_start(5);
    check("wd_start_clr", bus.tick_lost, 0);
    wait_rise("wd_rise2", 20);
    tick_en = 1'b0;
    cyc(25);
    check("wd_flag2", bus.tick_lost, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("wd_rst_clr", bus.tick_lost, 0);
    tick_en = 1'b1;

    // Reset mid-round
    cyc(5);
    do_start(9);
    wait_secs("mr_reach7", 7, 40);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mr_secs", bus.secs, 0);
    check("mr_running", bus.running, 0);
    check("mr_tens", bus.secs_tens, 0);
    check("mr_ones", bus.secs_ones, 0);
    check("mr_expired", bus.expired, 0);
    cyc(30);
    check("mr_idle_secs", bus.secs, 0);

    cyc(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

endmodule
